// File: rtl/video_stream_switch.sv
// N-channel video stream selector that only changes source on a frame boundary,
// blanks and flags no_signal when the selected source goes quiet, and counts forwarded frames.
module video_stream_switch #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEFAULT_CH = 0,
    parameter int unsigned TIMEOUT    = 2000000,
    localparam int unsigned CH_W      = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_vs,
    input  logic [NUM_CH-1:0]        in_de,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]          sel,
    input  logic                     sel_valid,
    output logic                     out_vs,
    output logic                     out_de,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          active_ch,
    output logic                     busy,
    output logic                     no_signal,
    output logic [15:0]              frame_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        STREAM  = 2'd1,
        LOST    = 2'd2
    } state_t;

    state_t                   state;
    logic [TW-1:0]            timer;
    logic [NUM_CH-1:0]        s1_vs;
    logic [NUM_CH-1:0]        s1_de;
    logic [NUM_CH*DATA_W-1:0] s1_data;
    logic [NUM_CH-1:0]        vs_prev;

    logic                     act_vs;
    logic                     act_de;
    logic [DATA_W-1:0]        act_data;
    logic                     rise_act;
    logic                     pass;
    logic                     do_switch;
    logic                     at_timeout;

    // Stage1 capture; vs history starts high so a source already in vsync at reset is not a frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vs   <= '1;
            s1_de   <= '0;
            s1_data <= '0;
            vs_prev <= '1;
        end else begin
            s1_vs   <= in_vs;
            s1_de   <= in_de;
            s1_data <= in_data;
            vs_prev <= s1_vs;
        end
    end

    assign act_vs     = s1_vs[active_ch];
    assign act_de     = s1_de[active_ch];
    assign act_data   = s1_data[active_ch*DATA_W +: DATA_W];
    assign rise_act   = act_vs & ~vs_prev[active_ch];
    assign pass       = (state == STREAM) | rise_act;
    assign do_switch  = sel_valid && (32'(sel) < NUM_CH) && !((sel == active_ch) && (state == STREAM));
    assign at_timeout = (timer == TW'(TIMEOUT - 1));

    // Control FSM with registered outputs; a select request outranks a rise or timeout in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_VS;
            timer     <= '0;
            active_ch <= CH_W'(DEFAULT_CH);
            busy      <= 1'b1;
            no_signal <= 1'b0;
            frame_cnt <= '0;
            out_vs    <= 1'b0;
            out_de    <= 1'b0;
            out_data  <= '0;
        end else if (do_switch) begin
            state     <= WAIT_VS;
            timer     <= '0;
            active_ch <= sel;
            busy      <= 1'b1;
            no_signal <= 1'b0;
            out_vs    <= 1'b0;
            out_de    <= 1'b0;
            out_data  <= '0;
        end else begin
            out_vs   <= pass & act_vs;
            out_de   <= pass & act_de;
            out_data <= (pass & act_de) ? act_data : '0;
            if (rise_act) begin
                state     <= STREAM;
                timer     <= '0;
                busy      <= 1'b0;
                no_signal <= 1'b0;
                frame_cnt <= frame_cnt + 16'd1;
            end else if (state != LOST) begin
                if (at_timeout) begin
                    state     <= LOST;
                    busy      <= 1'b0;
                    no_signal <= 1'b1;
                end else if (timer != '1) begin
                    timer <= timer + TW'(1);
                end
            end
        end
    end

endmodule
